// File: rtl/irq_vector_ctrl.sv
// Pending-interrupt controller fed by an 8-input active-low priority encoder.
// Holds one request at a time through an irq / irq_ack / eoi handshake with preemption and a watchdog.
module irq_vector_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] A,
    input  logic       GS,
    input  logic       mask_we,
    input  logic [7:0] mask_din,
    input  logic       irq_ack,
    input  logic       eoi,
    input  logic       err_clr,
    output logic       irq,
    output logic [2:0] vector,
    output logic       busy,
    output logic [7:0] mask,
    output logic       err,
    output logic [7:0] svc_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_SERV = 2'd2;
    localparam logic [15:0] TLAST  = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [2:0]  vec_q, vec_d;
    logic        irq_q, irq_d;
    logic        busy_q, busy_d;
    logic [7:0]  mask_q, mask_d;
    logic [7:0]  svc_q, svc_d;
    logic        err_q, err_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic        timeout_hit;

    logic [2:0] req_idx;
    logic       req_valid;

    assign req_idx   = ~A;
    assign req_valid = !GS && !mask_q[req_idx];

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        irq_d       = irq_q;
        busy_d      = busy_q;
        svc_d       = svc_q;
        tcnt_d      = tcnt_q;
        timeout_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_PEND;
                    vec_d   = req_idx;
                    tcnt_d  = 16'd0;
                    irq_d   = 1'b1;
                end
            end
            ST_PEND: begin
                tcnt_d = tcnt_q + 16'd1;
                // Ack beats timeout, which beats preemption and withdrawal.
                if (irq_ack) begin
                    state_d = ST_SERV;
                    irq_d   = 1'b0;
                    busy_d  = 1'b1;
                    if (svc_q != 8'hFF) svc_d = svc_q + 8'd1;
                end else if (tcnt_q == TLAST) begin
                    state_d     = ST_IDLE;
                    irq_d       = 1'b0;
                    timeout_hit = 1'b1;
                end else if (req_valid && (req_idx > vec_q)) begin
                    vec_d = req_idx;
                end else if (!(req_valid && (req_idx == vec_q))) begin
                    state_d = ST_IDLE;
                    irq_d   = 1'b0;
                end
            end
            ST_SERV: begin
                if (eoi) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                irq_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign mask_d = mask_we ? mask_din : mask_q;
    assign err_d  = timeout_hit | (err_q & ~err_clr);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            vec_q   <= 3'd0;
            irq_q   <= 1'b0;
            busy_q  <= 1'b0;
            mask_q  <= 8'h00;
            svc_q   <= 8'h00;
            err_q   <= 1'b0;
            tcnt_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            irq_q   <= irq_d;
            busy_q  <= busy_d;
            mask_q  <= mask_d;
            svc_q   <= svc_d;
            err_q   <= err_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign irq       = irq_q;
    assign vector    = vec_q;
    assign busy      = busy_q;
    assign mask      = mask_q;
    assign err       = err_q;
    assign svc_count = svc_q;

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// Bench for irq_vector_ctrl: directed handshake scenarios plus random traffic, all scored against a
// cycle-level behavioural model of the pending/service rules.
module tb_irq_vector_ctrl;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] A = 3'b111;
    logic       GS = 1'b1;
    logic       mask_we = 1'b0;
    logic [7:0] mask_din = 8'h00;
    logic       irq_ack = 1'b0;
    logic       eoi = 1'b0;
    logic       err_clr = 1'b0;
    logic       irq, busy, err;
    logic [2:0] vector;
    logic [7:0] mask, svc_count;

    irq_vector_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .A(A), .GS(GS), .mask_we(mask_we), .mask_din(mask_din),
        .irq_ack(irq_ack), .eoi(eoi), .err_clr(err_clr), .irq(irq), .vector(vector),
        .busy(busy), .mask(mask), .err(err), .svc_count(svc_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: 0 = idle, 1 = waiting for ack, 2 = being serviced
    int       m_st = 0;
    int       m_vec = 0;
    int       m_age = 0;
    logic [7:0] m_mask = 8'h00;
    int       m_svc = 0;
    logic     m_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int  line;
        bit  live;
        bit  tmo;
        line = 7 - int'(A);
        live = (GS == 1'b0) && (m_mask[line] == 1'b0);
        tmo  = 1'b0;
        if (!rst) begin
            m_st = 0; m_vec = 0; m_age = 0; m_mask = 8'h00; m_svc = 0; m_err = 1'b0;
            return;
        end
        if (m_st == 0) begin
            if (live) begin m_st = 1; m_vec = line; m_age = 0; end
        end else if (m_st == 1) begin
            if (irq_ack) begin
                m_st = 2;
                if (m_svc < 255) m_svc = m_svc + 1;
            end else if (m_age == TMO - 1) begin
                m_st = 0; tmo = 1'b1;
            end else if (live && line >= m_vec) begin
                m_vec = line; m_age = m_age + 1;
            end else begin
                m_st = 0;
            end
        end else begin
            if (eoi) m_st = 0;
        end
        if (tmo) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
        if (mask_we) m_mask = mask_din;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        chk("irq", irq, m_st == 1);
        chk("busy", busy, m_st == 2);
        chk("vector", vector, m_vec);
        chk("mask", mask, m_mask);
        chk("err", err, m_err);
        chk("svc_count", svc_count, m_svc);
        if (irq && busy) chk("irq_busy_excl", 1, 0);
    endtask

    task automatic idle_inputs();
        GS = 1'b1; A = 3'b111; mask_we = 1'b0; irq_ack = 1'b0; eoi = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        // reset
        rst = 1'b0; idle_inputs();
        cyc(); cyc();
        chk("rst_irq", irq, 0); chk("rst_vec", vector, 0); chk("rst_mask", mask, 0);
        rst = 1'b1;

        // basic handshake on line 2
        GS = 1'b0; A = 3'b101; cyc();
        chk("bas_irq", irq, 1); chk("bas_vec", vector, 3'd2);
        irq_ack = 1'b1; cyc();
        chk("bas_busy", busy, 1); chk("bas_svc", svc_count, 8'h01);
        irq_ack = 1'b0; GS = 1'b1; eoi = 1'b1; cyc();
        chk("bas_eoi_busy", busy, 0);
        eoi = 1'b0; cyc();
        chk("bas_idle_irq", irq, 0);

        // preemption, then ack racing a higher request
        GS = 1'b0; A = 3'b101; cyc();
        A = 3'b000; cyc();
        chk("pre_vec", vector, 3'd7); chk("pre_irq", irq, 1);
        A = 3'b001; irq_ack = 1'b1; cyc();
        chk("pre_ack_vec", vector, 3'd7); chk("pre_ack_busy", busy, 1);
        irq_ack = 1'b0; GS = 1'b1; eoi = 1'b1; cyc();
        eoi = 1'b0; cyc();

        // masking
        mask_we = 1'b1; mask_din = 8'h80; cyc();
        mask_we = 1'b0; GS = 1'b0; A = 3'b000; cyc(); cyc();
        chk("msk_irq", irq, 0);
        A = 3'b100; cyc();
        chk("msk_l3_vec", vector, 3'd3);
        mask_we = 1'b1; mask_din = 8'h08; cyc();
        mask_we = 1'b0; cyc();
        chk("msk_withdraw", irq, 0);
        GS = 1'b1; mask_we = 1'b1; mask_din = 8'h00; cyc();
        mask_we = 1'b0; cyc();

        // timeout: irq high for exactly TMO cycles
        GS = 1'b0; A = 3'b110; cyc();
        chk("tmo_irq0", irq, 1);
        repeat (TMO - 1) begin cyc(); chk("tmo_irq_hold", irq, 1); end
        GS = 1'b1; cyc();
        chk("tmo_irq_drop", irq, 0); chk("tmo_err", err, 1);
        err_clr = 1'b1; cyc();
        chk("tmo_clr", err, 0);
        err_clr = 1'b0; GS = 1'b0; cyc();
        repeat (TMO - 1) cyc();
        err_clr = 1'b1; cyc();
        chk("tmo_clr_race", err, 1);
        err_clr = 1'b0; GS = 1'b1; cyc(); cyc();

        // re-arm after eoi with request held
        GS = 1'b0; A = 3'b110; cyc();
        irq_ack = 1'b1; cyc();
        irq_ack = 1'b0; eoi = 1'b1; cyc();
        chk("rearm_gap", irq, 0);
        eoi = 1'b0; cyc();
        chk("rearm_irq", irq, 1); chk("rearm_vec", vector, 3'd1);

        // saturate the service counter
        for (int k = 0; k < 256; k++) begin
            irq_ack = 1'b1; cyc();
            irq_ack = 1'b0; eoi = 1'b1; cyc();
            eoi = 1'b0; cyc();
        end
        chk("svc_sat", svc_count, 8'hFF);

        // reset while pending and while in service
        rst = 1'b0; cyc(); rst = 1'b1;
        chk("rst_pend_irq", irq, 0); chk("rst_pend_svc", svc_count, 0);
        cyc();
        irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
        chk("pre_rst_busy", busy, 1);
        rst = 1'b0; cyc(); rst = 1'b1;
        chk("rst_serv_busy", busy, 0); chk("rst_serv_vec", vector, 0);
        idle_inputs(); cyc();

        // random traffic
        for (int k = 0; k < 4000; k++) begin
            rst      = ($urandom_range(0, 199) != 0);
            GS       = ($urandom_range(0, 3) == 0);
            A        = 3'($urandom);
            irq_ack  = ($urandom_range(0, 3) == 0);
            eoi      = ($urandom_range(0, 3) == 0);
            mask_we  = ($urandom_range(0, 15) == 0);
            mask_din = 8'($urandom & $urandom);
            err_clr  = ($urandom_range(0, 7) == 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
